// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS decode/issue slice:
//   - register-file and datapath widths (REG_ADDR_W, DATA_W)
//   - the opcode constants the decoder recognises
//   - operand-format classification and the decoded-instruction bundle
//   - a population-count helper used by the in-flight limit check
// No ports; imported by instr_decode and decode_issue.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Opcode field values (Instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Link register written by jal.
  localparam logic [REG_ADDR_W-1:0] REG_RA = 5'd31;

  // How an opcode uses the register file.
  typedef enum logic [2:0] {
    FMT_NONE,        // no register operands at all
    FMT_R,           // reads rs, rt; writes rd
    FMT_I_WRITE,     // reads rs; writes rt (immediate ALU ops, lw)
    FMT_READ2,       // reads rs, rt; writes nothing (sw, beq, bne)
    FMT_LINK         // writes $31 only (jal)
  } fmt_e;

  // Everything the issue register captures for one instruction.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [DATA_W-1:0]     imm;
  } decoded_t;

  function automatic fmt_e classify(input logic [5:0] op);
    if (op == OP_RTYPE)                                   return FMT_R;
    if (op inside {[OP_ADDI:OP_LUI], OP_LW})              return FMT_I_WRITE;
    if (op inside {OP_SW, OP_BEQ, OP_BNE})                return FMT_READ2;
    if (op == OP_JAL)                                     return FMT_LINK;
    return FMT_NONE;
  endfunction

  // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return op inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  function automatic logic [5:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) n += 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational MIPS operand decode. Extracts the source/destination
// register addresses, the write-enable, opcode/funct fields and the extended
// immediate from one 32-bit instruction word.
//
// Ports:
//   instr  in  32  instruction word
//   dec    out     decoded bundle (decoded_t): unused source addresses and an
//                  absent destination read as 0; reg_write only for a nonzero
//                  destination
// -----------------------------------------------------------------------------
module instr_decode
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  output decoded_t          dec
);

  logic [5:0]            op;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  always_comb begin
    // NOTE: defaults first so every path through the case assigns every field;
    // a missing assignment in some branch would otherwise infer a latch.
    dec        = '0;
    dec.opcode = op;
    dec.funct  = instr[5:0];

    case (classify(op))
      FMT_R: begin
        dec.src1 = rs;
        dec.src2 = rt;
        dec.dest = rd;
      end
      FMT_I_WRITE: begin
        dec.src1 = rs;
        dec.dest = rt;
      end
      FMT_READ2: begin
        dec.src1 = rs;
        dec.src2 = rt;
      end
      FMT_LINK: begin
        dec.dest = REG_RA;
      end
      default: ;
    endcase

    // An absent destination is already 0 here, and writes to $0 are discarded,
    // so a nonzero address is exactly "this instruction writes a register".
    dec.reg_write = (dec.dest != '0);

    dec.imm = is_zero_ext(op) ? {16'h0000, instr[15:0]}
                              : {{16{instr[15]}}, instr[15:0]};
  end

endmodule

// File: rtl/decode_issue.sv
// -----------------------------------------------------------------------------
// decode_issue
// Decodes one MIPS instruction per cycle into a single-entry issue register,
// tracking pending register writes in a 32-bit scoreboard (Busy). An
// instruction is held off while any register it reads or writes is still
// awaiting writeback, or while it would exceed MAX_INFLIGHT pending writes.
//
// Parameters:
//   MAX_INFLIGHT  1..31  maximum registers awaiting writeback
//
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   InstrValid     in   1   instruction word present
//   InstrReady     out  1   instruction accepted when high with InstrValid
//   Instr          in   32  instruction word
//   IssueValid     out  1   issue register holds a decoded instruction
//   IssueReady     in   1   downstream consumes the issue register
//   ReadRegister1  out  5   source address (rs) or 0
//   ReadRegister2  out  5   source address (rt) or 0
//   WriteRegister  out  5   destination address or 0
//   RegWrite       out  1   issued instruction writes WriteRegister
//   Opcode, Funct  out  6   Instr[31:26], Instr[5:0]
//   Imm            out  32  extended immediate
//   WbValid        in   1   a register retires this cycle
//   WbRegister     in   5   register being retired
//   Busy           out  32  scoreboard, bit 0 always 0
//
// Build option:
//   WB_BYPASS_EN   when defined, a register being written back this cycle is
//                  already treated as free by the hazard and in-flight checks,
//                  so a stalled instruction can be accepted in the writeback
//                  cycle instead of the cycle after.
// -----------------------------------------------------------------------------
module decode_issue
  import mips_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  InstrValid,
  output logic                  InstrReady,
  input  logic [DATA_W-1:0]     Instr,
  output logic                  IssueValid,
  input  logic                  IssueReady,
  output logic [REG_ADDR_W-1:0] ReadRegister1,
  output logic [REG_ADDR_W-1:0] ReadRegister2,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic                  RegWrite,
  output logic [5:0]            Opcode,
  output logic [5:0]            Funct,
  output logic [DATA_W-1:0]     Imm,
  input  logic                  WbValid,
  input  logic [REG_ADDR_W-1:0] WbRegister,
  output logic [NUM_REGS-1:0]   Busy
);

  localparam logic [5:0] INFLIGHT_LIMIT = 6'(MAX_INFLIGHT);

  decoded_t            dec;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] hazard_view;
  logic [5:0]          inflight;
  logic                src_hazard;
  logic                dest_hazard;
  logic                full_hazard;
  logic                hazard;
  logic                accept;

  instr_decode u_decode (
    .instr (Instr),
    .dec   (dec)
  );

  // Register being retired this cycle; $0 is never tracked so it is masked out.
  always_comb begin
    wb_mask = '0;
    if (WbValid && (WbRegister != '0)) wb_mask[WbRegister] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign hazard_view = busy_q & ~wb_mask;
`else
  assign hazard_view = busy_q;
`endif

  assign inflight = popcount(hazard_view);

  // Bit 0 of the scoreboard is never set, so an unused (zero) source or an
  // absent destination can never raise a hazard through this lookup.
  assign src_hazard  = hazard_view[dec.src1] | hazard_view[dec.src2];
  assign dest_hazard = hazard_view[dec.dest];
  assign full_hazard = dec.reg_write && (inflight == INFLIGHT_LIMIT);
  assign hazard      = src_hazard | dest_hazard | full_hazard;

  // Nothing is accepted in a reset cycle, even though the registers only
  // clear at the following edge.
  assign InstrReady = !reset && (!IssueValid || IssueReady) && !hazard;
  assign accept     = InstrValid && InstrReady;

  always_comb begin
    set_mask = '0;
    if (accept && dec.reg_write) set_mask[dec.dest] = 1'b1;
  end

  // Clear is applied before set, so an accept and a writeback of the same
  // register in one cycle leave the bit set for the new writer. Clearing a
  // bit that is not set is harmless, which covers stray writebacks.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of statement order.
    if (reset) busy_q <= '0;
    else       busy_q <= (busy_q & ~wb_mask) | set_mask;
  end

  assign Busy = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      IssueValid    <= 1'b0;
      ReadRegister1 <= '0;
      ReadRegister2 <= '0;
      WriteRegister <= '0;
      RegWrite      <= 1'b0;
      Opcode        <= '0;
      Funct         <= '0;
      Imm           <= '0;
    end else if (accept) begin
      IssueValid    <= 1'b1;
      ReadRegister1 <= dec.src1;
      ReadRegister2 <= dec.src2;
      WriteRegister <= dec.dest;
      RegWrite      <= dec.reg_write;
      Opcode        <= dec.opcode;
      Funct         <= dec.funct;
      Imm           <= dec.imm;
    end else if (IssueReady) begin
      // Consumed with nothing behind it; the payload is left as-is.
      IssueValid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// -----------------------------------------------------------------------------
// tb_decode_issue
// Directed scenarios followed by randomized traffic for decode_issue, built
// with MAX_INFLIGHT=2. A reference model derives the expected handshake,
// issue-register contents and scoreboard from the decode/hazard rules.
// -----------------------------------------------------------------------------
module tb_decode_issue;

  localparam int MAX_INFLIGHT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic        IssueValid;
  logic        IssueReady;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic        RegWrite;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic [31:0] Imm;
  logic        WbValid;
  logic [4:0]  WbRegister;
  logic [31:0] Busy;

  decode_issue #(.MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk           (clk),
    .reset         (reset),
    .InstrValid    (InstrValid),
    .InstrReady    (InstrReady),
    .Instr         (Instr),
    .IssueValid    (IssueValid),
    .IssueReady    (IssueReady),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .RegWrite      (RegWrite),
    .Opcode        (Opcode),
    .Funct         (Funct),
    .Imm           (Imm),
    .WbValid       (WbValid),
    .WbRegister    (WbRegister),
    .Busy          (Busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic        rw;
    logic [31:0] imm;
  } ref_dec_t;

  logic [31:0] m_busy;
  logic        m_valid;
  logic [4:0]  m_r1, m_r2, m_wr;
  logic        m_rw;
  logic [5:0]  m_op, m_fn;
  logic [31:0] m_imm;

  function automatic ref_dec_t ref_decode(input logic [31:0] w);
    ref_dec_t   r;
    logic [5:0] op;
    op    = w[31:26];
    r.s1  = 5'd0;
    r.s2  = 5'd0;
    r.d   = 5'd0;
    if (op == 6'h00) begin
      r.s1 = w[25:21]; r.s2 = w[20:16]; r.d = w[15:11];
    end else if ((op >= 6'h08 && op <= 6'h0F) || op == 6'h23) begin
      r.s1 = w[25:21]; r.d = w[20:16];
    end else if (op == 6'h2B || op == 6'h04 || op == 6'h05) begin
      r.s1 = w[25:21]; r.s2 = w[20:16];
    end else if (op == 6'h03) begin
      r.d = 5'd31;
    end
    r.rw  = (r.d != 5'd0);
    r.imm = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'h0000, w[15:0]}
                                                        : {{16{w[15]}}, w[15:0]};
    return r;
  endfunction

  function automatic logic model_ready();
    ref_dec_t    r;
    logic [31:0] eff;
    logic        haz;
    if (reset) return 1'b0;
    eff = m_busy;
`ifdef WB_BYPASS_EN
    if (WbValid && WbRegister != 5'd0) eff[WbRegister] = 1'b0;
`endif
    r   = ref_decode(Instr);
    haz = 1'b0;
    if (r.s1 != 0 && eff[r.s1]) haz = 1'b1;
    if (r.s2 != 0 && eff[r.s2]) haz = 1'b1;
    if (r.d  != 0 && eff[r.d])  haz = 1'b1;
    if (r.rw && $countones(eff) == MAX_INFLIGHT) haz = 1'b1;
    return (!m_valid || IssueReady) && !haz;
  endfunction

  task automatic model_update(input logic acc);
    ref_dec_t r;
    if (reset) begin
      m_busy = '0; m_valid = 1'b0;
      m_r1 = '0; m_r2 = '0; m_wr = '0; m_rw = 1'b0;
      m_op = '0; m_fn = '0; m_imm = '0;
      return;
    end
    if (WbValid && WbRegister != 5'd0) m_busy[WbRegister] = 1'b0;
    if (acc) begin
      r       = ref_decode(Instr);
      m_valid = 1'b1;
      m_r1 = r.s1; m_r2 = r.s2; m_wr = r.d; m_rw = r.rw;
      m_op = Instr[31:26]; m_fn = Instr[5:0]; m_imm = r.imm;
      if (r.rw) m_busy[r.d] = 1'b1;
    end else if (IssueReady) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already set: checks the handshake
  // before the rising edge, then the registered state just after it.
  task automatic run_cycle();
    logic exp_ready;
    #1;
    exp_ready = model_ready();
    check("instr_ready", {31'd0, InstrReady}, {31'd0, exp_ready});
    @(posedge clk);
    model_update(InstrValid && exp_ready);
    #1;
    check("issue_valid", {31'd0, IssueValid},    {31'd0, m_valid});
    check("read_reg1",   {27'd0, ReadRegister1}, {27'd0, m_r1});
    check("read_reg2",   {27'd0, ReadRegister2}, {27'd0, m_r2});
    check("write_reg",   {27'd0, WriteRegister}, {27'd0, m_wr});
    check("reg_write",   {31'd0, RegWrite},      {31'd0, m_rw});
    check("opcode",      {26'd0, Opcode},        {26'd0, m_op});
    check("funct",       {26'd0, Funct},         {26'd0, m_fn});
    check("imm",         Imm,                    m_imm);
    check("busy",        Busy,                   m_busy);
    @(negedge clk);
  endtask

  task automatic step(input logic rst, input logic iv, input logic [31:0] ins,
                      input logic ir, input logic wv, input logic [4:0] wr);
    reset      = rst;
    InstrValid = iv;
    Instr      = ins;
    IssueReady = ir;
    WbValid    = wv;
    WbRegister = wr;
    run_cycle();
  endtask

  localparam logic [31:0] ADD_10_8_9   = 32'h01095020;
  localparam logic [31:0] ADD_12_10_11 = 32'h014B6020;
  localparam logic [31:0] ORI_8        = 32'h3508FFFF;
  localparam logic [31:0] ADDI_8       = 32'h2108FFFF;
  localparam logic [31:0] ADD_11_1_2   = 32'h00225820;
  localparam logic [31:0] ADD_13_1_2   = 32'h00226820;
  localparam logic [31:0] SW_9_8       = 32'hAD090004;

  initial begin
    m_busy = '0; m_valid = 1'b0;
    m_r1 = '0; m_r2 = '0; m_wr = '0; m_rw = 1'b0;
    m_op = '0; m_fn = '0; m_imm = '0;
    reset = 1'b1; InstrValid = 1'b0; Instr = '0;
    IssueReady = 1'b1; WbValid = 1'b0; WbRegister = '0;
    @(negedge clk);

    // Reset with an instruction offered: must not be accepted.
    step(1, 1, ADD_10_8_9, 1, 0, 0);
    step(1, 1, ADD_10_8_9, 1, 0, 0);
    check("reset_busy",  Busy, 32'h0);
    check("reset_valid", {31'd0, IssueValid}, 32'd0);

    // add $10,$8,$9 issues one cycle later and marks $10 busy.
    step(0, 1, ADD_10_8_9, 1, 0, 0);
    check("add_valid", {31'd0, IssueValid}, 32'd1);
    check("add_rs",    {27'd0, ReadRegister1}, 32'd8);
    check("add_rt",    {27'd0, ReadRegister2}, 32'd9);
    check("add_rd",    {27'd0, WriteRegister}, 32'd10);
    check("add_rw",    {31'd0, RegWrite}, 32'd1);
    check("add_busy10", {31'd0, Busy[10]}, 32'd1);

    // RAW on $10 stalls until $10 is written back.
    step(0, 1, ADD_12_10_11, 1, 0, 0);
    step(0, 1, ADD_12_10_11, 1, 0, 0);
    check("raw_stall_busy", Busy, 32'h0000_0400);
    step(0, 1, ADD_12_10_11, 1, 1, 10);
    step(0, 1, ADD_12_10_11, 1, 0, 0);
    check("raw_done_busy", Busy, 32'h0000_1000);
    check("raw_done_rd",   {27'd0, WriteRegister}, 32'd12);

    // Immediate extension.
    step(0, 1, ORI_8, 1, 0, 0);
    check("ori_imm", Imm, 32'h0000_FFFF);
    step(0, 0, 32'h0, 1, 1, 8);
    step(0, 0, 32'h0, 1, 1, 12);
    check("drain_busy", Busy, 32'h0);
    step(0, 1, ADDI_8, 1, 0, 0);
    check("addi_imm", Imm, 32'hFFFF_FFFF);
    step(0, 0, 32'h0, 1, 1, 8);

    // In-flight limit of two: third writer stalls, a store still issues.
    step(0, 1, ADD_10_8_9, 1, 0, 0);
    step(0, 1, ADD_11_1_2, 1, 0, 0);
    step(0, 1, ADD_13_1_2, 1, 0, 0);
    step(0, 1, ADD_13_1_2, 1, 0, 0);
    check("limit_busy", Busy, 32'h0000_0C00);
    step(0, 1, SW_9_8, 1, 0, 0);
    check("sw_rs", {27'd0, ReadRegister1}, 32'd8);
    check("sw_rt", {27'd0, ReadRegister2}, 32'd9);
    check("sw_rw", {31'd0, RegWrite}, 32'd0);
    check("sw_wr", {27'd0, WriteRegister}, 32'd0);
    step(0, 1, ADD_13_1_2, 1, 1, 10);
    step(0, 1, ADD_13_1_2, 1, 0, 0);
    check("limit_release_busy", Busy, 32'h0000_2800);
    step(0, 0, 32'h0, 1, 1, 11);
    step(0, 0, 32'h0, 1, 1, 13);

    // Downstream back-pressure for three cycles, then release.
    step(0, 1, ADD_10_8_9, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, ORI_8, 0, 0, 0);
      check("hold_wr", {27'd0, WriteRegister}, 32'd10);
    end
    step(0, 1, ORI_8, 1, 0, 0);
    check("release_wr",  {27'd0, WriteRegister}, 32'd8);
    check("release_imm", Imm, 32'h0000_FFFF);

    // Stray writebacks leave the scoreboard alone.
    step(0, 0, 32'h0, 1, 1, 0);
    step(0, 0, 32'h0, 1, 1, 5);
    check("stray_wb_busy", Busy, 32'h0000_0500);
    step(0, 0, 32'h0, 1, 1, 10);
    step(0, 0, 32'h0, 1, 1, 8);

    // Same-cycle set and clear of $10: set wins.
    step(0, 1, ADD_10_8_9, 1, 1, 10);
    check("set_wins_busy", Busy, 32'h0000_0400);

    // Reset mid-operation with a held instruction and pending writes.
    step(0, 1, ADD_11_1_2, 0, 0, 0);
    step(1, 1, ADD_13_1_2, 0, 0, 0);
    check("midreset_busy",  Busy, 32'h0);
    check("midreset_valid", {31'd0, IssueValid}, 32'd0);
    check("midreset_wr",    {27'd0, WriteRegister}, 32'd0);

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  op;
      logic [31:0] w;
      case ($urandom_range(0, 9))
        0, 1:    op = 6'h00;
        2:       op = 6'(8 + $urandom_range(0, 7));
        3:       op = 6'h23;
        4:       op = 6'h2B;
        5:       op = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05;
        6:       op = 6'h03;
        7:       op = 6'h02;
        default: op = 6'(8 + $urandom_range(0, 7));
      endcase
      w = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom), 6'($urandom)};
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), w,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) != 0),
           5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, range 1-31: maximum registers awaiting writeback.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port InstrValid  input  1  instruction word present.
REQ-005 SHALL have port InstrReady  output  1  instruction accepted this cycle when high together with InstrValid.
REQ-006 SHALL have port Instr  input  32  MIPS instruction word.
REQ-007 SHALL have port IssueValid  output  1  issue register holds a decoded instruction.
REQ-008 SHALL have port IssueReady  input  1  downstream consumes the issue register.
REQ-009 SHALL have ports ReadRegister1, ReadRegister2, WriteRegister  output  5 each  register file addresses.
REQ-010 SHALL have port RegWrite  output  1  issued instruction writes WriteRegister.
REQ-011 SHALL have ports Opcode, Funct  output  6 each  Instr[31:26] and Instr[5:0].
REQ-012 SHALL have port Imm  output  32  extended immediate.
REQ-013 SHALL have ports WbValid  input  1 and WbRegister  input  5  writeback retire of one register.
REQ-014 SHALL have port Busy  output  32  scoreboard; bit 0 always 0.

Function
REQ-015 SHALL decode: opcode 0 -> sources rs,rt, destination rd; 0x08-0x0F and 0x23 -> source rs, destination rt; 0x2B, 0x04, 0x05 -> sources rs,rt, no destination; 0x03 -> destination 31; all other opcodes -> no sources, no destination.
REQ-016 SHALL drive unused source addresses and the unused WriteRegister to 0.
REQ-017 SHALL set RegWrite=1 only when a destination exists and it is nonzero.
REQ-018 SHALL zero-extend Imm for opcodes 0x0C, 0x0D, 0x0E and sign-extend Instr[15:0] for all others.
REQ-019 SHALL flag a hazard when any nonzero source or nonzero destination has its Busy bit set, or when RegWrite=1 and popcount(Busy)==MAX_INFLIGHT.
REQ-020 SHALL drive InstrReady = (!IssueValid || IssueReady) && !hazard, computed combinationally from current-cycle state.
REQ-021 SHALL load all issue outputs on accept, one cycle after Instr is presented; the latency is 1 cycle.
REQ-022 SHALL set Busy[WriteRegister] on an accept with RegWrite=1.
REQ-023 SHALL clear IssueValid when IssueReady=1 and no new accept occurs, and SHALL hold all issue outputs stable while IssueValid=1 and IssueReady=0.
REQ-024 SHALL clear Busy[WbRegister] on WbValid=1.
REQ-025 SHALL ignore a writeback to register 0 or to a non-busy register.
REQ-026 SHALL, when an accept sets and a writeback clears the same bit in one cycle, leave the bit set.
REQ-027 SHALL support back-to-back accepts at a rate of one per cycle when there is no hazard.

Reset
REQ-028 SHALL, on reset, clear Busy to 0, IssueValid to 0, and set ReadRegister1/2, WriteRegister, RegWrite, Opcode, Funct and Imm to 0.
REQ-029 SHALL, on reset mid-operation, discard the held instruction and all pending writebacks, and SHALL drive InstrReady=0 in the reset cycle.

Configuration
REQ-030 SHALL, with WB_BYPASS_EN defined, treat a register matching WbRegister with WbValid=1 as not busy for the hazard check in that same cycle, and SHALL count it as freed for the MAX_INFLIGHT check.
REQ-031 SHALL, without WB_BYPASS_EN, check hazards against registered Busy only, so a writeback unblocks a stalled instruction one cycle later.

Structure
REQ-032 SHALL take opcode constants, REG_ADDR_W=5 and DATA_W=32 from shared package mips_pkg.
REQ-033 SHALL place combinational decode (REQ-015..018) in sub-module instr_decode; the scoreboard and handshake SHALL reside in decode_issue.

Verification
REQ-034 SHALL cover: after reset, present 0x01095020 (add $10,$8,$9) -> the next cycle IssueValid=1, ReadRegister1=8, ReadRegister2=9, WriteRegister=10, RegWrite=1, and Busy[10]=1.
REQ-035 SHALL cover: present 0x014B6020 (add $12,$10,$11) with Busy[10]=1 -> InstrReady=0 until WbValid/WbRegister=10; accept the following cycle, or the same cycle with WB_BYPASS_EN.
REQ-036 SHALL cover: present 0x3508FFFF (ori $8,$8,0xFFFF) -> Imm=0x0000FFFF; present 0x2108FFFF (addi) -> Imm=0xFFFFFFFF.
REQ-037 SHALL cover: MAX_INFLIGHT=2 with three writes to distinct registers -> the third stalls until a writeback; a sw (0xAD090004) with free sources still issues.
REQ-038 SHALL cover: IssueReady=0 for 3 cycles -> outputs stable and InstrReady=0; then IssueReady=1 -> the pending instruction is accepted in that cycle.
REQ-039 SHALL cover: writeback to $0 or to a non-busy register -> Busy unchanged; same-cycle accept to $10 and writeback of $10 -> Busy[10]=1.
